// File: rtl/serial_loader_pkg.sv
// serial_loader shared types and sizing.
// State set includes CHECK, used only when PARITY_CHECK_EN is defined.
package serial_loader_pkg;

  localparam int WIDTH_DEF = 8;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_width(WIDTH_DEF);

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LOAD,
    CLEAR,
    CHECK
  } state_t;

endpackage

// File: rtl/serial_loader_shift_reg_in.sv
// Serial-in/parallel-out shift register with enable and sync clear.
// Exposes its next value so the loader can capture a finished word on the same edge.
module shift_reg_in #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] q;

  // next value: clear wins over shift, otherwise hold
  always_comb begin
    q_nxt = q;
    if (clr) begin
      q_nxt = '0;
    end else if (en) begin
      if (MSB_FIRST) begin
        q_nxt = {q[WIDTH-2:0], din};
      end else begin
        q_nxt = {din, q[WIDTH-1:1]};
      end
    end
  end

  // shift storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

endmodule

// File: rtl/serial_loader.sv
// Serial-to-parallel feeder driving a set/reset register (s, r, d).
// Optional even-parity check on each word is enabled by PARITY_CHECK_EN.
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_loader,
  input  logic             rst_n_loader,
  input  logic             start_loader,
  input  logic             clr_req_loader,
  input  logic             sin_loader,
  input  logic             sin_valid_loader,
  output logic             s_loader,
  output logic             r_loader,
  output logic [WIDTH-1:0] d_loader,
  output logic             busy_loader,
`ifdef PARITY_CHECK_EN
  output logic             err_loader,
`endif
  output logic             done_loader
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             sh_en;
  logic             sh_clr;
  logic [WIDTH-1:0] sh_nxt;

`ifdef PARITY_CHECK_EN
  logic par_q;
  logic par_nxt;
  logic par_ok;

  // sh_nxt equals the held word while in CHECK
  assign par_ok = ~(^{sh_nxt, par_q});
`endif

  shift_reg_in #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_sr (
    .clk  (clk_loader),
    .rst_n(rst_n_loader),
    .clr  (sh_clr),
    .en   (sh_en),
    .din  (sin_loader),
    .q_nxt(sh_nxt)
  );

  // next-state, counter and shift control
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    sh_en   = 1'b0;
    sh_clr  = 1'b0;
`ifdef PARITY_CHECK_EN
    par_nxt = par_q;
`endif
    unique case (state)
      IDLE: begin
        if (clr_req_loader) begin
          nxt = CLEAR;
        end else if (start_loader) begin
          nxt     = SHIFT;
          cnt_nxt = '0;
          sh_clr  = 1'b1;
        end
      end
      SHIFT: begin
        if (clr_req_loader) begin
          nxt = CLEAR;
        end else if (sin_valid_loader) begin
`ifdef PARITY_CHECK_EN
          if (cnt == CW'(WIDTH)) begin
            par_nxt = sin_loader;
            nxt     = CHECK;
          end else begin
            sh_en   = 1'b1;
            cnt_nxt = cnt + CW'(1);
          end
`else
          sh_en   = 1'b1;
          cnt_nxt = cnt + CW'(1);
          if (cnt == LAST) begin
            nxt = LOAD;
          end
`endif
        end
      end
      LOAD:  nxt = IDLE;
      CLEAR: nxt = IDLE;
`ifdef PARITY_CHECK_EN
      CHECK: nxt = par_ok ? LOAD : IDLE;
`endif
      default: nxt = IDLE;
    endcase
  end

  // state and bit counter
  always_ff @(posedge clk_loader or negedge rst_n_loader) begin
    if (!rst_n_loader) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

`ifdef PARITY_CHECK_EN
  // received parity bit and mismatch pulse
  always_ff @(posedge clk_loader or negedge rst_n_loader) begin
    if (!rst_n_loader) begin
      par_q      <= 1'b0;
      err_loader <= 1'b0;
    end else begin
      par_q      <= par_nxt;
      err_loader <= (state == CHECK) && !par_ok;
    end
  end
`endif

  // registered outputs, decoded from the state being entered
  always_ff @(posedge clk_loader or negedge rst_n_loader) begin
    if (!rst_n_loader) begin
      s_loader    <= 1'b0;
      done_loader <= 1'b0;
      r_loader    <= 1'b0;
      busy_loader <= 1'b0;
      d_loader    <= '0;
    end else begin
      s_loader    <= (nxt == LOAD);
      done_loader <= (nxt == LOAD);
      r_loader    <= (nxt == CLEAR);
      busy_loader <= (nxt != IDLE);
      if (nxt == LOAD) begin
        d_loader <= sh_nxt;
      end
    end
  end

endmodule

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader (default MSB-first, WIDTH 8).
// Adds parity bits and a bad-parity case when PARITY_CHECK_EN is defined.
module tb_serial_loader;
  import serial_loader_pkg::*;

  localparam int W = WIDTH_DEF;
`ifdef PARITY_CHECK_EN
  localparam int NB    = W + 1;
  localparam int EXTRA = 1;
`else
  localparam int NB    = W;
  localparam int EXTRA = 0;
`endif

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clr   = 1'b0;
  logic         sin   = 1'b0;
  logic         sv    = 1'b0;
  logic         s;
  logic         r;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
`ifdef PARITY_CHECK_EN
  logic         err;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_loader dut (
    .clk_loader      (clk),
    .rst_n_loader    (rst_n),
    .start_loader    (start),
    .clr_req_loader  (clr),
    .sin_loader      (sin),
    .sin_valid_loader(sv),
    .s_loader        (s),
    .r_loader        (r),
    .d_loader        (d),
    .busy_loader     (busy),
`ifdef PARITY_CHECK_EN
    .err_loader      (err),
`endif
    .done_loader     (done)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // k-th transmitted bit of word w: MSB first, then even parity
  function automatic logic bit_of(input logic [W-1:0] w, input int k);
    if (k >= W) return ^w;
    return w[W-1-k];
  endfunction

  // mode 0: contiguous, 1: valid toggles 1,0,.., 2: random gaps
  task automatic run_word(input logic [W-1:0] w, input int mode,
                          input string tag);
    int   acc;
    int   i;
    int   lat;
    logic v;
    acc = 0;
    i   = 0;
    lat = 0;
    start = 1'b1;
    step;
    lat++;
    start = 1'b0;
    chk({tag, "_busy_start"}, busy, 1);
    while (acc < NB) begin
      if (mode == 0) v = 1'b1;
      else if (mode == 1) v = (i % 2 == 0);
      else v = (i > 40) ? 1'b1 : 1'($urandom_range(0, 1));
      sv  = v;
      sin = v ? bit_of(w, acc) : 1'($urandom_range(0, 1));
      step;
      i++;
      lat++;
      if (v) acc++;
      if (!(acc == NB && EXTRA == 0)) begin
        chk({tag, "_s_early"}, s, 0);
        chk({tag, "_r_shift"}, r, 0);
        chk({tag, "_busy_shift"}, busy, 1);
      end
    end
    sv  = 1'b0;
    sin = 1'b0;
    repeat (EXTRA) begin
      step;
      lat++;
    end
    chk({tag, "_s"}, s, 1);
    chk({tag, "_done"}, done, 1);
    chk({tag, "_r_load"}, r, 0);
    chk({tag, "_d"}, d, w);
    chk({tag, "_busy_load"}, busy, 1);
    if (mode == 0) chk({tag, "_latency"}, lat, W + 1 + 2 * EXTRA);
    step;
    chk({tag, "_s_pulse"}, s, 0);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_busy_idle"}, busy, 0);
    chk({tag, "_d_hold"}, d, w);
  endtask

`ifdef PARITY_CHECK_EN
  task automatic run_bad(input logic [W-1:0] w, input logic [W-1:0] dprev);
    start = 1'b1;
    step;
    start = 1'b0;
    for (int k = 0; k < NB; k++) begin
      sv  = 1'b1;
      sin = (k == W) ? ~bit_of(w, k) : bit_of(w, k);
      step;
    end
    sv = 1'b0;
    chk("bad_s_check", s, 0);
    step;
    chk("bad_err", err, 1);
    chk("bad_s", s, 0);
    chk("bad_busy", busy, 0);
    chk("bad_d", d, dprev);
    step;
    chk("bad_err_pulse", err, 0);
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] w;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s", s, 0);
    chk("rst_r", r, 0);
    chk("rst_d", d, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    step;

    run_word(8'hA5, 0, "t1");
    run_word(8'h3C, 1, "t2");

    // abort after 4 bits of FF; the valid bit in the clear cycle is dropped
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (4) begin
      sv  = 1'b1;
      sin = 1'b1;
      step;
    end
    clr = 1'b1;
    step;
    clr = 1'b0;
    sv  = 1'b0;
    chk("abort_r", r, 1);
    chk("abort_s", s, 0);
    chk("abort_d", d, 8'h3C);
    chk("abort_busy", busy, 1);
    step;
    chk("abort_r_pulse", r, 0);
    chk("abort_s_after", s, 0);
    chk("abort_busy_idle", busy, 0);
    chk("abort_d_hold", d, 8'h3C);

    // start and clear together in IDLE: clear wins
    start = 1'b1;
    clr   = 1'b1;
    step;
    start = 1'b0;
    clr   = 1'b0;
    chk("both_r", r, 1);
    chk("both_s", s, 0);
    chk("both_busy", busy, 1);
    step;
    chk("both_r_pulse", r, 0);
    chk("both_busy_idle", busy, 0);
    step;
    chk("both_start_dropped", busy, 0);

    // asynchronous reset mid-word
    start = 1'b1;
    step;
    start = 1'b0;
    repeat (5) begin
      sv  = 1'b1;
      sin = 1'($urandom_range(0, 1));
      step;
    end
    sv = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_s", s, 0);
    chk("async_r", r, 0);
    chk("async_d", d, 0);
    chk("async_busy", busy, 0);
    chk("async_done", done, 0);
    step;
    rst_n = 1'b1;
    step;
    run_word(8'h01, 0, "t5");

`ifdef PARITY_CHECK_EN
    run_word(8'h07, 0, "par_ok");
    run_bad(8'h07, 8'h07);
`endif

    for (int n = 0; n < 8; n++) begin
      w = W'($urandom);
      run_word(w, (n % 2 == 0) ? 2 : 0, "rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
Name: serial_loader

Overview:
- Upstream feeder for the 8-bit set/reset register stage.
- Deserialises a bit stream into a parallel byte and drives the register's control inputs: load strobe s, clear r and data d.
- One FSM sequences shift, load and clear, so the downstream register sees a single-cycle load with stable data. It never sees a partial byte.

Parameters:
- WIDTH, 8, parallel word width; 8 matches the register stage.
- MSB_FIRST, 1, 1 = first received bit lands in d[WIDTH-1]; 0 = first bit lands in d[0].

Ports:
- clk_loader  in  1  single system clock; all state changes on its rising edge.
- rst_n_loader  in  1  asynchronous, active-low reset.
- start_loader  in  1  one-cycle request to begin receiving a word.
- clr_req_loader  in  1  request to clear the downstream register.
- sin_loader  in  1  serial data bit.
- sin_valid_loader  in  1  sin_loader is valid this cycle.
- s_loader  out  1  load strobe to the register (its s input).
- r_loader  out  1  clear strobe to the register (its r input).
- d_loader  out  WIDTH  parallel data to the register (its d input).
- busy_loader  out  1  high in any state other than IDLE.
- done_loader  out  1  one-cycle pulse, coincident with s_loader.

Behaviour:
- Reset (async, on rst_n_loader low):
  - state = IDLE, bit counter = 0, shift register = 0.
  - All outputs 0, d_loader = 0.
  - Reset mid-operation discards any partial word; no s_loader or r_loader is emitted.
- All outputs are registered.
- States: IDLE, SHIFT, LOAD, CLEAR (plus CHECK when PARITY_CHECK_EN is defined).
- IDLE:
  - clr_req_loader=1 -> CLEAR.
  - Else start_loader=1 -> SHIFT, with counter cleared.
  - If both are high in the same cycle, clear wins and start is dropped.
- SHIFT:
  - Each cycle with sin_valid_loader=1: shift in one bit (direction per MSB_FIRST) and increment the counter.
  - Cycles with sin_valid_loader=0 hold state; there is no timeout.
  - On the WIDTH-th accepted bit -> LOAD.
  - start_loader is ignored while in SHIFT.
  - clr_req_loader=1 aborts: partial word discarded, -> CLEAR; a bit valid in that same cycle is dropped.
- LOAD (one cycle):
  - d_loader = shift register, s_loader = 1, done_loader = 1; then -> IDLE.
  - d_loader holds this value after LOAD until the next LOAD or reset.
- CLEAR (one cycle): r_loader = 1, d_loader unchanged; then -> IDLE.
- Latency:
  - s_loader is high in the cycle after the edge that accepts the last bit.
  - Back-to-back words with no valid gaps: start at cycle 0 -> s_loader at cycle WIDTH+1.
- s_loader and r_loader are never high together.
- Counter width is $clog2(WIDTH+1). Counter resets to 0 on each new start; no wrap-around occurs inside a word.

Optional Feature:
- Macro: PARITY_CHECK_EN.
- When defined:
  - After WIDTH data bits, one extra valid bit is taken as even parity -> CHECK.
  - Match -> LOAD.
  - Mismatch -> IDLE with no s_loader, and a one-cycle err_loader output pulse.
  - Latency grows by one accepted bit.
- When undefined: no parity bit, no CHECK state, no err_loader port.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, SHIFT, LOAD, CLEAR, CHECK);
  - the WIDTH default constant;
  - a localparam for counter width.
- Natural sub-module: shift_reg_in (WIDTH-bit serial-in/parallel-out with enable and sync clear). The FSM stays in serial_loader.

Test Plan:
- Reset, then start, then 8 contiguous valid bits of 8'hA5 MSB-first -> s_loader=1 and done_loader=1 for exactly one cycle at cycle 9, d_loader=8'hA5, r_loader=0 throughout.
- Same word 8'h3C with sin_valid_loader toggled 1,0,1,0,… -> load occurs only after 8 accepted bits, d_loader=8'h3C, busy_loader high until after LOAD.
- clr_req_loader asserted after 4 bits of 8'hFF -> r_loader pulses one cycle, no s_loader, d_loader keeps its previous value (8'h3C).
- start_loader and clr_req_loader together in IDLE -> r_loader pulse only; FSM back in IDLE, busy_loader=0 two cycles later.
- rst_n_loader low after 5 bits -> outputs 0 immediately (asynchronously). A new start then 8'h01 -> d_loader=8'h01 with no residue from the aborted word.
- With PARITY_CHECK_EN: 8'h07 plus parity 1 -> load; 8'h07 plus parity 0 -> err_loader pulse, no s_loader.
